agu_radix_param: RTL and testbench
==================================

// Module: agu_radix_param
// PURPOSE
//  Parametrised NTT address generator: for every stage, emits K=2**P_LOG2 conflict-free operand indices per beat.
//  Each index is a bank number plus a memory address. Generalises the fixed K=2 AGU to radix-K and any N.
//  Adds forward/inverse stage order and valid/ready backpressure. Feeds the bank-switch / memory read path.
// PARAMETERS
//  N_LOG2  10  log2 of transform length N; must be a multiple of P_LOG2
//  P_LOG2  1   log2 of ports/banks K per beat (1..3)
//  S       N_LOG2/P_LOG2 (localparam)  number of radix-K stages
//  MA_W    N_LOG2-P_LOG2 (localparam)  memory-address width
//  ST_W    $clog2(S) (min 1, localparam)  stage-index width
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            synchronous, active-low reset
//  start      in   1            1-cycle request to begin a transform; honoured only in IDLE
//  mode_inv   in   1            sampled with start: 0 = stages 0..S-1, 1 = stages S-1..0
//  out_ready  in   1            consumer accepts the current beat
//  out_valid  out  1            beat on ma_idx/bn_idx/stage_out is valid
//  ma_idx     out  K*MA_W       lane m at bits [m*MA_W +: MA_W]
//  bn_idx     out  K*P_LOG2     lane m at bits [m*P_LOG2 +: P_LOG2]
//  stage_out  out  ST_W         stage index of the current beat
//  busy       out  1            high in every state except IDLE
//  done       out  1            1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE; all counters, pipeline regs and outputs go to 0.
//   Reset mid-transform aborts with no done pulse.
//  FSM:
//   IDLE -start-> RUN (latch mode_inv; stage = 0 or S-1; group j = 0).
//   RUN -> DRAIN after the last (stage, j) pair enters the pipeline.
//   DRAIN -> IDLE when the pipeline is empty; done pulses in that cycle.
//  Enumeration: j counts 0..N/K-1 within a stage, then the stage steps by +1 (fwd) or -1 (inv).
//   Total beats = S*N/K.
//  Order for stage s, lane m: write j as (S-1) P_LOG2-bit digits; insert m as digit s.
//   Lower digits stay in place; digits at s and above move up one position.
//  Translation:
//   bn = (sum of all S digits of order) mod K.
//   ma = order >> P_LOG2.
//   The K lanes of one beat always have K distinct bn values.
//  Pipeline, 3 register stages, all gated by adv = !out_valid || out_ready:
//   counter -> order reg -> translated output reg.
//   First out_valid appears 3 cycles after start is sampled, provided out_ready stays high.
//  Backpressure: when out_valid && !out_ready, every register and counter holds.
//   Outputs stay stable until accepted; no beat is dropped or duplicated.
//  out_valid stays high while beats are available; consecutive beats are permitted.
//   Data is 0 when out_valid=0 after reset; after that it holds its last value.
//  start while busy: ignored; mode_inv is not re-sampled.
//  start in the same cycle as done: ignored; the FSM is still leaving DRAIN.
//  Wrap: j wraps to 0 when the stage advances. stage never exceeds S-1 and never goes below 0.
// TESTING
//  T1 N_LOG2=4,P_LOG2=1, fwd, out_ready=1: beat 0 = orders {0,1} -> ma={0,0}, bn={0,1}, stage 0.
//     Beat 3 = orders {6,7} -> ma={3,3}, bn={0,1}.
//  T2 same config, stage 3, j=0: orders {0,8} -> ma={0,4}, bn={0,1}.
//     32 beats in total, then done one cycle after beat 31 is accepted.
//  T3 mode_inv=1: first beat has stage_out=3 with ma={0,4}; last beat has stage_out=0.
//  T4 N_LOG2=6,P_LOG2=2 (K=4), stage 1, j=0: orders {0,4,8,12} -> ma={0,1,2,3}, bn={0,1,2,3}.
//     Every beat has bn lanes forming a permutation of 0..3.
//  T5 random out_ready stalls: outputs hold while stalled.
//     Scoreboard sees exactly S*N/K beats, in order, none lost or repeated.
//  T6 rst_n low mid-RUN: next cycle busy=0, out_valid=0, outputs 0, no done.
//     start pulsed while busy: no effect on the beat sequence.

Source files
------------

// File: rtl/agu_radix_param_if.sv
// Request/stream bundle between the radix-K NTT address generator and the bank-switch read path.
// The master side drives start/mode/ready; the slave side (the generator) drives the beat and status.
interface agu_radix_param_if #(
  parameter int N_LOG2 = 10,
  parameter int P_LOG2 = 1
);
  localparam int K    = 1 << P_LOG2;
  localparam int S    = N_LOG2 / P_LOG2;
  localparam int MA_W = N_LOG2 - P_LOG2;
  localparam int ST_W = (S > 1) ? $clog2(S) : 1;

  logic                start;
  logic                mode_inv;
  logic                out_ready;
  logic                out_valid;
  logic [K*MA_W-1:0]   ma_idx;
  logic [K*P_LOG2-1:0] bn_idx;
  logic [ST_W-1:0]     stage_out;
  logic                busy;
  logic                done;

  modport master (
    output start, mode_inv, out_ready,
    input  out_valid, ma_idx, bn_idx, stage_out, busy, done
  );

  modport slave (
    input  start, mode_inv, out_ready,
    output out_valid, ma_idx, bn_idx, stage_out, busy, done
  );
endinterface

// File: rtl/agu_radix_param.sv
// Radix-K NTT address generator: per stage, emits K conflict-free (bank, address) operand
// indices per beat, in forward or inverse stage order, under valid/ready backpressure.
module agu_radix_param #(
  parameter int N_LOG2 = 10,
  parameter int P_LOG2 = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  agu_radix_param_if.slave bus
);
  localparam int K    = 1 << P_LOG2;
  localparam int S    = N_LOG2 / P_LOG2;
  localparam int MA_W = N_LOG2 - P_LOG2;
  localparam int ST_W = (S > 1) ? $clog2(S) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ST_W-1:0] STAGE_LAST = ST_W'(S - 1);
  localparam logic [MA_W-1:0] J_LAST     = '1;

  // Splice lane digit m into j at digit position s; digits of j at s and above shift up one.
  function automatic logic [N_LOG2-1:0] insert_digit(
    input logic [MA_W-1:0]   j,
    input logic [ST_W-1:0]   s,
    input logic [P_LOG2-1:0] m
  );
    logic [N_LOG2-1:0] ord;
    int                pos;
    ord = N_LOG2'(m) << (int'(s) * P_LOG2);
    for (int d = 0; d < S - 1; d++) begin
      pos = (d < int'(s)) ? d : d + 1;
      ord = ord | (N_LOG2'(j[d*P_LOG2 +: P_LOG2]) << (pos * P_LOG2));
    end
    return ord;
  endfunction

  // Bank number: sum of all base-K digits, wrapping mod K in a P_LOG2-bit accumulator.
  function automatic logic [P_LOG2-1:0] digit_sum(input logic [N_LOG2-1:0] ord);
    logic [P_LOG2-1:0] acc;
    acc = '0;
    for (int d = 0; d < S; d++) begin
      acc = acc + ord[d*P_LOG2 +: P_LOG2];
    end
    return acc;
  endfunction

  logic [1:0]          state_q, state_d;
  logic                mode_q, mode_d;
  logic [ST_W-1:0]     cnt_stage_q, cnt_stage_d;
  logic [MA_W-1:0]     cnt_j_q, cnt_j_d;

  logic                vld_p0_q, vld_p0_d;
  logic [ST_W-1:0]     stage_p0_q, stage_p0_d;
  logic [MA_W-1:0]     j_p0_q, j_p0_d;

  logic                vld_p1_q, vld_p1_d;
  logic [ST_W-1:0]     stage_p1_q, stage_p1_d;
  logic [K*N_LOG2-1:0] ord_p1_q, ord_p1_d;

  logic                vld_p2_q, vld_p2_d;
  logic [ST_W-1:0]     stage_p2_q, stage_p2_d;
  logic [K*MA_W-1:0]   ma_p2_q, ma_p2_d;
  logic [K*P_LOG2-1:0] bn_p2_q, bn_p2_d;

  logic                adv;
  logic                pipe_empty;
  logic                issue;
  logic                last_pair;
  logic [ST_W-1:0]     stage_end;

  // A stalled output beat freezes the whole pipe, counters included.
  always_comb begin
    adv        = !vld_p2_q || bus.out_ready;
    pipe_empty = !vld_p0_q && !vld_p1_q && !vld_p2_q;
    stage_end  = mode_q ? '0 : STAGE_LAST;
    last_pair  = (cnt_j_q == J_LAST) && (cnt_stage_q == stage_end);
  end

  // Control FSM and (stage, j) counter
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_stage_d = cnt_stage_q;
    cnt_j_d     = cnt_j_q;
    issue       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          mode_d      = bus.mode_inv;
          cnt_stage_d = bus.mode_inv ? STAGE_LAST : '0;
          cnt_j_d     = '0;
        end
      end
      ST_RUN: begin
        if (adv) begin
          issue = 1'b1;
          if (last_pair) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_j_d = cnt_j_q + 1'b1;
            if (cnt_j_q == J_LAST) begin
              cnt_stage_d = mode_q ? (cnt_stage_q - 1'b1) : (cnt_stage_q + 1'b1);
            end
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // p0: captured (stage, j) pair
  always_comb begin
    vld_p0_d   = vld_p0_q;
    stage_p0_d = stage_p0_q;
    j_p0_d     = j_p0_q;
    if (adv) begin
      vld_p0_d = issue;
      if (issue) begin
        stage_p0_d = cnt_stage_q;
        j_p0_d     = cnt_j_q;
      end
    end
  end

  // p1: per-lane operand order
  always_comb begin
    vld_p1_d   = vld_p1_q;
    stage_p1_d = stage_p1_q;
    ord_p1_d   = ord_p1_q;
    if (adv) begin
      vld_p1_d = vld_p0_q;
      if (vld_p0_q) begin
        stage_p1_d = stage_p0_q;
        for (int m = 0; m < K; m++) begin
          ord_p1_d[m*N_LOG2 +: N_LOG2] = insert_digit(j_p0_q, stage_p0_q, P_LOG2'(m));
        end
      end
    end
  end

  // p2: bank/address translation, presented on the output
  always_comb begin
    vld_p2_d   = vld_p2_q;
    stage_p2_d = stage_p2_q;
    ma_p2_d    = ma_p2_q;
    bn_p2_d    = bn_p2_q;
    if (adv) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        stage_p2_d = stage_p1_q;
        for (int m = 0; m < K; m++) begin
          ma_p2_d[m*MA_W +: MA_W]     = ord_p1_q[m*N_LOG2 + P_LOG2 +: MA_W];
          bn_p2_d[m*P_LOG2 +: P_LOG2] = digit_sum(ord_p1_q[m*N_LOG2 +: N_LOG2]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      cnt_stage_q <= '0;
      cnt_j_q     <= '0;
      vld_p0_q    <= 1'b0;
      stage_p0_q  <= '0;
      j_p0_q      <= '0;
      vld_p1_q    <= 1'b0;
      stage_p1_q  <= '0;
      ord_p1_q    <= '0;
      vld_p2_q    <= 1'b0;
      stage_p2_q  <= '0;
      ma_p2_q     <= '0;
      bn_p2_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_stage_q <= cnt_stage_d;
      cnt_j_q     <= cnt_j_d;
      vld_p0_q    <= vld_p0_d;
      stage_p0_q  <= stage_p0_d;
      j_p0_q      <= j_p0_d;
      vld_p1_q    <= vld_p1_d;
      stage_p1_q  <= stage_p1_d;
      ord_p1_q    <= ord_p1_d;
      vld_p2_q    <= vld_p2_d;
      stage_p2_q  <= stage_p2_d;
      ma_p2_q     <= ma_p2_d;
      bn_p2_q     <= bn_p2_d;
    end
  end

  // done is combinational so a start in the same cycle still sees the FSM in DRAIN.
  assign bus.out_valid = vld_p2_q;
  assign bus.ma_idx    = ma_p2_q;
  assign bus.bn_idx    = bn_p2_q;
  assign bus.stage_out = stage_p2_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DRAIN) && pipe_empty;

endmodule

// File: tb/tb_agu_radix_param.sv
// Randomised bench for agu_radix_param: two configurations (K=2, N=16 and K=4, N=64) checked
// beat by beat against an arithmetic base-K model, with ready stalls, start pokes and resets.
module tb_agu_radix_param;
  localparam int A_N = 4;
  localparam int A_P = 1;
  localparam int B_N = 6;
  localparam int B_P = 2;
  localparam int A_MA = A_N - A_P;
  localparam int B_MA = B_N - B_P;

  logic clk;
  logic rst_n;
  logic start_r;
  logic mode_r;
  logic ready_r;
  int   sel;

  int n_cmp;
  int n_err;

  agu_radix_param_if #(.N_LOG2(A_N), .P_LOG2(A_P)) ifa ();
  agu_radix_param_if #(.N_LOG2(B_N), .P_LOG2(B_P)) ifb ();

  agu_radix_param #(.N_LOG2(A_N), .P_LOG2(A_P)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  agu_radix_param #(.N_LOG2(B_N), .P_LOG2(B_P)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  assign ifa.start     = start_r && (sel == 0);
  assign ifb.start     = start_r && (sel == 1);
  assign ifa.mode_inv  = mode_r;
  assign ifb.mode_inv  = mode_r;
  assign ifa.out_ready = ready_r;
  assign ifb.out_ready = ready_r;

  always #5 clk = ~clk;

  logic v_valid, v_busy, v_done;
  int   v_stage;
  int   v_ma[4];
  int   v_bn[4];

  always_comb begin
    v_valid = 1'b0;
    v_busy  = 1'b0;
    v_done  = 1'b0;
    v_stage = 0;
    for (int m = 0; m < 4; m++) begin
      v_ma[m] = 0;
      v_bn[m] = 0;
    end
    if (sel == 0) begin
      v_valid = ifa.out_valid;
      v_busy  = ifa.busy;
      v_done  = ifa.done;
      v_stage = int'(ifa.stage_out);
      for (int m = 0; m < 2; m++) begin
        v_ma[m] = int'(ifa.ma_idx[m*A_MA +: A_MA]);
        v_bn[m] = int'(ifa.bn_idx[m*A_P +: A_P]);
      end
    end else begin
      v_valid = ifb.out_valid;
      v_busy  = ifb.busy;
      v_done  = ifb.done;
      v_stage = int'(ifb.stage_out);
      for (int m = 0; m < 4; m++) begin
        v_ma[m] = int'(ifb.ma_idx[m*B_MA +: B_MA]);
        v_bn[m] = int'(ifb.bn_idx[m*B_P +: B_P]);
      end
    end
  end

  int obs_ma[64][4];
  int obs_bn[64][4];
  int obs_st[64];
  int n_obs;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: index order in base-K digits; lane m becomes digit s, higher digits of j move up.
  function automatic void model(input int nl, input int pl, input int s, input int j, input int m,
                                output int ma, output int bn);
    int k, ks, order, x;
    k  = 1 << pl;
    ks = 1;
    for (int i = 0; i < s; i++) ks = ks * k;
    order = (j / ks) * ks * k + m * ks + (j % ks);
    ma = order / k;
    bn = 0;
    x  = order;
    for (int d = 0; d < nl / pl; d++) begin
      bn = bn + (x % k);
      x  = x / k;
    end
    bn = bn % k;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, int'(v_valid), 0);
    chk({tag, "_busy"}, int'(v_busy), 0);
    chk({tag, "_done"}, int'(v_done), 0);
    chk({tag, "_stage"}, v_stage, 0);
    for (int m = 0; m < 4; m++) begin
      chk({tag, "_ma"}, v_ma[m], 0);
      chk({tag, "_bn"}, v_bn[m], 0);
    end
  endtask

  task automatic run_xfer(input int which, input bit inv, input int stall_pct, input bit poke);
    int nl, pl, k, s_n, per, nbeats, cyc, got, first_v, stg, j, e_ma, e_bn, mask, h_stage;
    bit held;
    int h_ma[4];
    int h_bn[4];
    sel    = which;
    nl     = (which == 0) ? A_N : B_N;
    pl     = (which == 0) ? A_P : B_P;
    k      = 1 << pl;
    s_n    = nl / pl;
    per    = (1 << nl) / k;
    nbeats = s_n * per;
    n_obs  = 0;
    @(negedge clk);
    start_r = 1'b1;
    mode_r  = inv;
    ready_r = 1'b1;
    @(posedge clk);
    cyc = 0; got = 0; first_v = -1; held = 1'b0; h_stage = 0;
    for (int m = 0; m < 4; m++) begin h_ma[m] = 0; h_bn[m] = 0; end
    @(negedge clk);
    start_r = 1'b0;
    while (got < nbeats && cyc < 4000) begin
      if (poke && (cyc == 6 || cyc == 17)) begin
        start_r = 1'b1;
        mode_r  = !inv;
      end else begin
        start_r = 1'b0;
        mode_r  = inv;
      end
      chk("busy_run", int'(v_busy), 1);
      chk("done_early", int'(v_done), 0);
      if (held) begin
        chk("hold_valid", int'(v_valid), 1);
        chk("hold_stage", v_stage, h_stage);
        for (int m = 0; m < k; m++) begin
          chk("hold_ma", v_ma[m], h_ma[m]);
          chk("hold_bn", v_bn[m], h_bn[m]);
        end
      end
      ready_r = ($urandom_range(99) >= stall_pct);
      held = 1'b0;
      if (v_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          if (stall_pct == 0) chk("first_latency", first_v, 3);
        end
        if (ready_r) begin
          stg = inv ? (s_n - 1 - got / per) : (got / per);
          j   = got % per;
          chk("stage", v_stage, stg);
          mask = 0;
          for (int m = 0; m < k; m++) begin
            model(nl, pl, stg, j, m, e_ma, e_bn);
            chk("ma", v_ma[m], e_ma);
            chk("bn", v_bn[m], e_bn);
            mask = mask | (1 << v_bn[m]);
            obs_ma[got][m] = v_ma[m];
            obs_bn[got][m] = v_bn[m];
          end
          chk("bn_perm", mask, (1 << k) - 1);
          obs_st[got] = v_stage;
          got++;
          n_obs = got;
        end else begin
          held    = 1'b1;
          h_stage = v_stage;
          for (int m = 0; m < 4; m++) begin
            h_ma[m] = v_ma[m];
            h_bn[m] = v_bn[m];
          end
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start_r = 1'b0;
    mode_r  = inv;
    if (got < nbeats) chk("beats_timeout", got, nbeats);
    chk("done_pulse", int'(v_done), 1);
    chk("valid_after_last", int'(v_valid), 0);
    chk("busy_in_done", int'(v_busy), 1);
    start_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r = 1'b0;
    chk("start_with_done_ignored", int'(v_busy), 0);
    chk("done_single", int'(v_done), 0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      chk("idle_busy", int'(v_busy), 0);
      chk("idle_valid", int'(v_valid), 0);
      chk("idle_done", int'(v_done), 0);
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start_r = 1'b0; mode_r = 1'b0; ready_r = 1'b0; sel = 0;
    n_cmp = 0; n_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sel = 0; #1;
    check_idle_zero("rst_a");
    sel = 1; #1;
    check_idle_zero("rst_b");

    // T1/T2: K=2 forward
    run_xfer(0, 1'b0, 0, 1'b0);
    chk("t1_count", n_obs, 32);
    chk("t1_b0_ma0", obs_ma[0][0], 0);  chk("t1_b0_ma1", obs_ma[0][1], 0);
    chk("t1_b0_bn0", obs_bn[0][0], 0);  chk("t1_b0_bn1", obs_bn[0][1], 1);
    chk("t1_b0_st", obs_st[0], 0);
    chk("t1_b3_ma0", obs_ma[3][0], 3);  chk("t1_b3_ma1", obs_ma[3][1], 3);
    chk("t1_b3_bn0", obs_bn[3][0], 0);  chk("t1_b3_bn1", obs_bn[3][1], 1);
    chk("t2_b24_st", obs_st[24], 3);
    chk("t2_b24_ma0", obs_ma[24][0], 0); chk("t2_b24_ma1", obs_ma[24][1], 4);
    chk("t2_b24_bn0", obs_bn[24][0], 0); chk("t2_b24_bn1", obs_bn[24][1], 1);

    // T3: inverse order
    run_xfer(0, 1'b1, 0, 1'b0);
    chk("t3_b0_st", obs_st[0], 3);
    chk("t3_b0_ma0", obs_ma[0][0], 0);  chk("t3_b0_ma1", obs_ma[0][1], 4);
    chk("t3_b31_st", obs_st[31], 0);

    // T4: K=4, stage 1 starts at beat 16
    run_xfer(1, 1'b0, 0, 1'b0);
    chk("t4_count", n_obs, 48);
    chk("t4_b16_st", obs_st[16], 1);
    for (int m = 0; m < 4; m++) begin
      chk("t4_b16_ma", obs_ma[16][m], m);
      chk("t4_b16_bn", obs_bn[16][m], m);
    end

    // T5: random stalls plus start pulses while busy
    run_xfer(0, 1'b0, 40, 1'b1);
    run_xfer(1, 1'b1, 30, 1'b1);
    run_xfer(1, 1'b0, 60, 1'b0);

    // T6: reset mid-run
    sel = 0;
    @(negedge clk);
    start_r = 1'b1; mode_r = 1'b0; ready_r = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_valid", int'(v_valid), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_zero("mid_rst");
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_done", int'(v_done), 0);
      chk("post_rst_busy", int'(v_busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
